// File: rtl/nco_pkg.sv
// Shared types for the multi-channel NCO/PDM block: waveform modes and the
// per-channel configuration record.
package nco_pkg;

    localparam int N_CH_DEF  = 2;
    localparam int ACC_W_DEF = 20;
    localparam int FTW_W_DEF = 8;
    localparam int PDM_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_SAW = 2'd0,
        MODE_SQR = 2'd1,
        MODE_TRI = 2'd2,
        MODE_OFF = 2'd3
    } mode_e;

    typedef struct packed {
        logic                 en;
        logic [FTW_W_DEF-1:0] ftw;
        mode_e                mode;
    } nco_cfg_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nco_pdm_multi_channel.sv
// One NCO channel: phase accumulator, shadow/active config with wrap-aligned
// transfer, waveform shaper and first-order error-feedback PDM modulator.
module nco_pdm_channel
    import nco_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int FTW_W = FTW_W_DEF,
    parameter int PDM_W = PDM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic             i_en,
    input  logic [FTW_W-1:0] i_ftw,
    input  logic [1:0]       i_mode,
    output logic             o_pending,
    output logic             o_pdm,
    output logic             o_sync
);

    typedef struct packed {
        logic             en;
        logic [FTW_W-1:0] ftw;
        mode_e            mode;
    } ch_cfg_t;

    ch_cfg_t            r_act;
    ch_cfg_t            r_shd;
    logic               r_pend;
    logic [ACC_W-1:0]   r_acc;
    logic [PDM_W-1:0]   r_err;
    logic               r_pdm;
    logic               r_sync;

    logic [ACC_W:0]     w_acc_sum;
    logic               w_carry;
    logic               w_accept;
    logic               w_xfer;
    logic [PDM_W-1:0]   w_saw;
    logic [PDM_W-1:0]   w_tri;
    logic [PDM_W-1:0]   w_amp;
    logic [PDM_W:0]     w_pdm_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, ACC_W'(r_act.ftw)};
    assign w_carry   = w_acc_sum[ACC_W];
    assign w_accept  = i_wr & ~r_pend;
    // Retunes wait for a wrap; a stopped channel or a disabling write needs no phase alignment.
    assign w_xfer    = r_pend & (~r_act.en | ~r_shd.en | w_carry);

    assign w_saw = r_acc[ACC_W-1 -: PDM_W];
    assign w_tri = r_acc[ACC_W-1] ? ~r_acc[ACC_W-2 -: PDM_W] : r_acc[ACC_W-2 -: PDM_W];

    always_comb begin
        w_amp = '0;
        case (r_act.mode)
            MODE_SAW: w_amp = w_saw;
            MODE_SQR: w_amp = {PDM_W{r_acc[ACC_W-1]}};
            MODE_TRI: w_amp = w_tri;
            default:  w_amp = '0;
        endcase
    end

    assign w_pdm_sum = {1'b0, r_err} + {1'b0, w_amp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act  <= '0;
            r_shd  <= '0;
            r_pend <= 1'b0;
            r_acc  <= '0;
            r_err  <= '0;
            r_pdm  <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shd  <= '{en: i_en, ftw: i_ftw, mode: mode_e'(i_mode)};
                r_pend <= 1'b1;
            end else if (w_xfer) begin
                r_act  <= r_shd;
                r_pend <= 1'b0;
            end

            if (r_act.en) begin
                r_acc  <= w_acc_sum[ACC_W-1:0];
                r_err  <= w_pdm_sum[PDM_W-1:0];
                r_pdm  <= w_pdm_sum[PDM_W];
                r_sync <= w_carry;
            end else begin
                r_acc  <= '0;
                r_err  <= '0;
                r_pdm  <= 1'b0;
                r_sync <= 1'b0;
            end
        end
    end

    assign o_pending = r_pend;
    assign o_pdm     = r_pdm;
    assign o_sync    = r_sync;

endmodule

// File: rtl/nco_pdm_multi.sv
// Multi-channel NCO with PDM outputs: config channel decode, ready mux and
// one independent channel instance per output pin.
module nco_pdm_multi
    import nco_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    parameter  int ACC_W = ACC_W_DEF,
    parameter  int FTW_W = FTW_W_DEF,
    parameter  int PDM_W = PDM_W_DEF,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [FTW_W-1:0] i_cfg_ftw,
    input  logic [1:0]       i_cfg_mode,
    input  logic             i_cfg_en,
    output logic [N_CH-1:0]  o_pdm_out,
    output logic [N_CH-1:0]  o_sync_out
);

    logic [N_CH-1:0] w_wr;
    logic [N_CH-1:0] w_pend;
    logic            w_ready;

    // Indices beyond N_CH match no channel, so such writes are acked and dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (i_cfg_ch == CH_W'(c)) w_ready = ~w_pend[c];
        end
    end

    assign o_cfg_ready = w_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_wr[g] = i_cfg_valid & (i_cfg_ch == CH_W'(g));

        nco_pdm_channel #(
            .ACC_W (ACC_W),
            .FTW_W (FTW_W),
            .PDM_W (PDM_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr      (w_wr[g]),
            .i_en      (i_cfg_en),
            .i_ftw     (i_cfg_ftw),
            .i_mode    (i_cfg_mode),
            .o_pending (w_pend[g]),
            .o_pdm     (o_pdm_out[g]),
            .o_sync    (o_sync_out[g])
        );
    end

endmodule

// File: tb/tb_nco_pdm_multi.sv
// Scenario bench for nco_pdm_multi against an arithmetic per-channel reference model.
module tb_nco_pdm_multi;

    localparam int M    = 1 << 20;
    localparam int HALF = 1 << 19;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ch = 1'b0;
    logic [7:0] cfg_ftw = '0;
    logic [1:0] cfg_mode = '0;
    logic       cfg_en = 1'b0;
    logic       cfg_ready;
    logic [1:0] pdm_out;
    logic [1:0] sync_out;

    logic       cfg2_valid = 1'b0;
    logic [1:0] cfg2_ch = '0;
    logic [7:0] cfg2_ftw = '0;
    logic [1:0] cfg2_mode = '0;
    logic       cfg2_en = 1'b0;
    logic       cfg2_ready;
    logic [2:0] pdm2_out;
    logic [2:0] sync2_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int m_en[2], m_ftw[2], m_mode[2], s_en[2], s_ftw[2], s_mode[2];
    int m_pend[2], m_acc[2], m_err[2], m_pdm[2], m_sync[2];

    nco_pdm_multi dut (
        .clk(clk), .rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_ch(cfg_ch), .i_cfg_ftw(cfg_ftw), .i_cfg_mode(cfg_mode), .i_cfg_en(cfg_en),
        .o_pdm_out(pdm_out), .o_sync_out(sync_out)
    );

    nco_pdm_multi #(.N_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_cfg_valid(cfg2_valid), .o_cfg_ready(cfg2_ready),
        .i_cfg_ch(cfg2_ch), .i_cfg_ftw(cfg2_ftw), .i_cfg_mode(cfg2_mode), .i_cfg_en(cfg2_en),
        .o_pdm_out(pdm2_out), .o_sync_out(sync2_out)
    );

    always #5 clk = ~clk;

    function automatic int amp_of(input int acc, input int mode);
        int t;
        case (mode)
            0: return acc / 4096;
            1: return (acc >= HALF) ? 255 : 0;
            2: begin
                t = (acc / 2048) % 256;
                return (acc >= HALF) ? 255 - t : t;
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] exp_pdm();
        return {m_pdm[1] != 0, m_pdm[0] != 0};
    endfunction

    function automatic logic [1:0] exp_sync();
        return {m_sync[1] != 0, m_sync[0] != 0};
    endfunction

    function automatic logic exp_ready();
        return m_pend[int'(cfg_ch)] == 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_en[c] = 0; m_ftw[c] = 0; m_mode[c] = 0;
            s_en[c] = 0; s_ftw[c] = 0; s_mode[c] = 0;
            m_pend[c] = 0; m_acc[c] = 0; m_err[c] = 0; m_pdm[c] = 0; m_sync[c] = 0;
        end
    endtask

    // Advance the reference one clock using the inputs as they stand before the edge.
    task automatic tick();
        int n_en[2], n_ftw[2], n_mode[2], n_sen[2], n_sftw[2], n_smode[2];
        int n_pend[2], n_acc[2], n_err[2], n_pdm[2], n_sync[2];
        for (int c = 0; c < 2; c++) begin
            int carry;
            int s;
            n_en[c] = m_en[c]; n_ftw[c] = m_ftw[c]; n_mode[c] = m_mode[c];
            n_sen[c] = s_en[c]; n_sftw[c] = s_ftw[c]; n_smode[c] = s_mode[c];
            n_pend[c] = m_pend[c];
            carry = (m_en[c] != 0 && m_acc[c] + m_ftw[c] >= M) ? 1 : 0;
            if (cfg_valid && int'(cfg_ch) == c && m_pend[c] == 0) begin
                n_sen[c] = int'(cfg_en); n_sftw[c] = int'(cfg_ftw); n_smode[c] = int'(cfg_mode);
                n_pend[c] = 1;
            end else if (m_pend[c] != 0 && (m_en[c] == 0 || s_en[c] == 0 || carry != 0)) begin
                n_en[c] = s_en[c]; n_ftw[c] = s_ftw[c]; n_mode[c] = s_mode[c];
                n_pend[c] = 0;
            end
            if (m_en[c] != 0) begin
                s = m_err[c] + amp_of(m_acc[c], m_mode[c]);
                n_err[c] = s % 256; n_pdm[c] = s / 256;
                n_acc[c] = (m_acc[c] + m_ftw[c]) % M; n_sync[c] = carry;
            end else begin
                n_err[c] = 0; n_pdm[c] = 0; n_acc[c] = 0; n_sync[c] = 0;
            end
        end
        @(posedge clk);
        #1;
        m_en = n_en; m_ftw = n_ftw; m_mode = n_mode;
        s_en = n_sen; s_ftw = n_sftw; s_mode = n_smode;
        m_pend = n_pend; m_acc = n_acc; m_err = n_err; m_pdm = n_pdm; m_sync = n_sync;
        cyc++;
    endtask

    task automatic cfg_write(input int ch, input int en, input int ftw, input int mode);
        cfg_ch = 1'(ch); cfg_en = 1'(en); cfg_ftw = 8'(ftw); cfg_mode = 2'(mode);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        tests++;
        if (pdm_out !== 2'b00) begin fails++; $display("FAIL reset_pdm got=%b exp=00", pdm_out); end
        tests++;
        if (sync_out !== 2'b00) begin fails++; $display("FAIL reset_sync got=%b exp=00", sync_out); end
        tests++;
        if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    endtask

    task automatic test_out_of_range();
        int nz = 0;
        cfg2_ch = 2'd3; cfg2_en = 1'b1; cfg2_ftw = 8'hFF; cfg2_mode = 2'd0; cfg2_valid = 1'b1;
        #1;
        tests++;
        if (cfg2_ready !== 1'b1) begin fails++; $display("FAIL oor_ready got=%b exp=1", cfg2_ready); end
        tick();
        cfg2_valid = 1'b0;
        repeat (300) begin
            tick();
            if (pdm2_out !== 3'b000 || sync2_out !== 3'b000 || cfg2_ready !== 1'b1) nz++;
        end
        tests++;
        if (nz != 0) begin fails++; $display("FAIL oor_no_effect got=%0d active cycles exp=0", nz); end
        cfg2_ch = 2'd0; cfg2_en = 1'b0; cfg2_valid = 1'b1;
        tick();
        cfg2_valid = 1'b0;
        tests++;
        if (cfg2_ready !== 1'b0) begin fails++; $display("FAIL inrange_pending got=%b exp=0", cfg2_ready); end
        tick();
        tests++;
        if (cfg2_ready !== 1'b1) begin fails++; $display("FAIL inrange_release got=%b exp=1", cfg2_ready); end
    endtask

    task automatic test_enable();
        int n = 0, ones = 0, bad = 0, ch1 = 0;
        cfg_write(0, 1, 8'h80, 0);
        while (!sync_out[0] && n < 20000) begin
            tick(); n++;
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
            if (pdm_out[1] !== 1'b0 || sync_out[1] !== 1'b0) ch1++;
        end
        // one cycle to apply the write, then 2^20/0x80 steps to the first wrap
        tests++;
        if (n != 8193) begin fails++; $display("FAIL enable_first_sync got=%0d exp=8193", n); end
        for (int k = 1; k <= 8192; k++) begin
            tick();
            ones += int'(pdm_out[0]);
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
            if (pdm_out[1] !== 1'b0 || sync_out[1] !== 1'b0) ch1++;
        end
        tests++;
        if (sync_out[0] !== 1'b1) begin fails++; $display("FAIL enable_period got=%b exp=1", sync_out[0]); end
        tests++;
        if (ones < 4079 || ones > 4081) begin fails++; $display("FAIL saw_density got=%0d exp=4080+-1", ones); end
        tests++;
        if (ch1 != 0) begin fails++; $display("FAIL ch1_idle got=%0d active cycles exp=0", ch1); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL enable_trace got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_retune();
        int d, n = 0, bad = 0;
        logic prev_ready;
        d = $urandom_range(100, 2000);
        repeat (d) begin
            tick();
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        cfg_write(0, 1, 8'h40, 0);
        tests++;
        if (cfg_ready !== 1'b0) begin fails++; $display("FAIL retune_ready_drop got=%b exp=0", cfg_ready); end
        cfg_write(0, 1, 8'h20, 0);
        tests++;
        if (cfg_ready !== 1'b0) begin fails++; $display("FAIL retune_second_write got=%b exp=0", cfg_ready); end
        prev_ready = cfg_ready;
        while (!sync_out[0] && n < 9000) begin
            prev_ready = cfg_ready;
            tick(); n++;
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        tests++;
        if (cfg_ready !== 1'b1 || prev_ready !== 1'b0)
            begin fails++; $display("FAIL retune_ready_edge got=%b%b exp=01", prev_ready, cfg_ready); end
        // queue the square setting now; it lands on the wrap that ends this interval
        cfg_write(0, 1, 8'h80, 1);
        n = 1;
        while (!sync_out[0] && n < 20000) begin
            tick(); n++;
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        tests++;
        if (n != 16384) begin fails++; $display("FAIL retune_interval got=%0d exp=16384", n); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL retune_trace got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_square();
        int ones1 = 0, ones2 = 0, bad = 0;
        for (int k = 1; k <= 8192; k++) begin
            tick();
            if (k <= 4096) ones1 += int'(pdm_out[0]);
            else           ones2 += int'(pdm_out[0]);
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        tests++;
        if (ones1 != 0) begin fails++; $display("FAIL square_low got=%0d exp=0", ones1); end
        tests++;
        if (ones2 < 4079 || ones2 > 4081) begin fails++; $display("FAIL square_high got=%0d exp=4080+-1", ones2); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL square_trace got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_async_reset();
        cfg_write(0, 1, 8'h10, 2);
        tests++;
        if (cfg_ready !== 1'b0) begin fails++; $display("FAIL async_pre_pending got=%b exp=0", cfg_ready); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({pdm_out, sync_out, cfg_ready} !== 5'b00001)
            begin fails++; $display("FAIL async_clear got=%b exp=00001", {pdm_out, sync_out, cfg_ready}); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_triangle();
        int n = 0, bad = 0, shift = 0, ones0 = 0, ones1 = 0;
        bit h0[0:8193];
        bit h1[0:8193];
        cfg_write(0, 1, 8'h80, 2);
        cfg_write(1, 1, 8'h80, 2);
        while (!sync_out[0] && n < 20000) begin
            tick(); n++;
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        tests++;
        if (n != 8192) begin fails++; $display("FAIL tri_first_sync got=%0d exp=8192", n); end
        h0[0] = pdm_out[0]; h1[0] = pdm_out[1];
        for (int k = 1; k <= 8193; k++) begin
            tick();
            if (k == 1) begin
                tests++;
                if (sync_out !== 2'b10) begin fails++; $display("FAIL tri_sync_offset got=%b exp=10", sync_out); end
            end
            h0[k] = pdm_out[0]; h1[k] = pdm_out[1];
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        for (int k = 1; k <= 8193; k++) if (h1[k] != h0[k-1]) shift++;
        for (int k = 1; k <= 8192; k++) begin ones0 += int'(h0[k]); ones1 += int'(h1[k+1]); end
        tests++;
        if (shift != 0) begin fails++; $display("FAIL tri_shift got=%0d differing cycles exp=0", shift); end
        tests++;
        if (ones0 < 4079 || ones0 > 4081 || ones1 < 4079 || ones1 > 4081)
            begin fails++; $display("FAIL tri_density got=%0d/%0d exp=4080+-1", ones0, ones1); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL tri_trace got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_disable();
        int d, n = 0, bad = 0;
        d = $urandom_range(500, 3000);
        repeat (d) begin
            tick();
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        cfg_write(1, 0, 8'h80, 2);
        tests++;
        if (cfg_ready !== 1'b0) begin fails++; $display("FAIL disable_pending got=%b exp=0", cfg_ready); end
        tick();
        tick();
        tests++;
        if (pdm_out[1] !== 1'b0 || sync_out[1] !== 1'b0 || cfg_ready !== 1'b1)
            begin fails++; $display("FAIL disable_2cyc got=%b%b%b exp=001", pdm_out[1], sync_out[1], cfg_ready); end
        cfg_write(1, 1, 8'h80, 0);
        n = 0;
        while (!sync_out[1] && n < 20000) begin
            tick(); n++;
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) bad++;
        end
        tests++;
        if (n != 8193) begin fails++; $display("FAIL reenable_restart got=%0d exp=8193", n); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL disable_trace got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_random();
        int bad = 0, first = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_ch = 1'($urandom_range(0, 1));
                cfg_en = ($urandom_range(0, 3) != 0);
                cfg_ftw = 8'($urandom_range(0, 255));
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_valid = 1'b1;
            end
            tick();
            cfg_valid = 1'b0;
            if ({pdm_out, sync_out, cfg_ready} !== {exp_pdm(), exp_sync(), exp_ready()}) begin
                bad++;
                if (first < 0) first = cyc;
            end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL random_trace got=%0d bad cycles (first at %0d) exp=0", bad, first); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_out_of_range();
        test_enable();
        test_retune();
        test_square();
        test_async_reset();
        test_triangle();
        test_disable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
